// File: rtl/bounce_box_gen.sv
// bounce_box_gen
//   Draws a solid box that bounces around the visible area of a VGA frame,
//   plus a one-pixel white border around the screen edge. The box moves
//   once every FRAME_DIV frames, and its colour changes whenever it hits an
//   edge.
//
// Ports
//   clk_i        : single clock
//   reset_i      : asynchronous, active-low reset
//   pause_i      : high freezes position, direction, colour and frame count
//   row_i        : current scan row from the VGA driver
//   column_i     : current scan column from the VGA driver
//   rgb_o        : pixel colour {R,G,B}, combinational (zero latency)
//   frame_tick_o : one-clk pulse when the scan enters (0,0)
//   box_x_o      : left edge of the box (registered)
//   box_y_o      : top edge of the box (registered)
module bounce_box_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int BOX_SIZE  = 32,
  parameter int STEP      = 2,
  parameter int FRAME_DIV = 1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       pause_i,
  input  logic [8:0] row_i,
  input  logic [9:0] column_i,
  output logic [2:0] rgb_o,
  output logic       frame_tick_o,
  output logic [9:0] box_x_o,
  output logic [8:0] box_y_o
);

  // All position arithmetic is done at 11 bits so that sums never wrap.
  localparam logic [10:0] X_MAX    = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] Y_MAX    = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] STEP_W   = 11'(STEP);
  localparam logic [10:0] BOX_W    = 11'(BOX_SIZE);
  localparam logic [10:0] H_W      = 11'(H_ACTIVE);
  localparam logic [10:0] V_W      = 11'(V_ACTIVE);
  localparam logic [7:0]  DIV_LAST = 8'(FRAME_DIV - 1);

  typedef enum logic { X_RIGHT, X_LEFT } x_dir_e;
  typedef enum logic { Y_DOWN,  Y_UP   } y_dir_e;

  logic [8:0] row_q,    row_d;
  logic [9:0] col_q,    col_d;
  logic [7:0] cnt_q,    cnt_d;
  logic [9:0] box_x_q,  box_x_d;
  logic [8:0] box_y_q,  box_y_d;
  logic [2:0] colour_q, colour_d;
  x_dir_e     x_dir_q,  x_dir_d;
  y_dir_e     y_dir_q,  y_dir_d;

  logic        frame_tick;
  logic        move;
  logic        bounce_x, bounce_y;
  logic [10:0] x_ext, y_ext, c_ext, r_ext;

  function automatic logic [2:0] next_colour(input logic [2:0] c);
    case (c)
      3'b100:  next_colour = 3'b010;
      3'b010:  next_colour = 3'b001;
      3'b001:  next_colour = 3'b110;
      3'b110:  next_colour = 3'b011;
      3'b011:  next_colour = 3'b101;
      default: next_colour = 3'b100;
    endcase
  endfunction

  always_comb begin
    row_d    = row_i;
    col_d    = column_i;
    cnt_d    = cnt_q;
    box_x_d  = box_x_q;
    box_y_d  = box_y_q;
    colour_d = colour_q;
    x_dir_d  = x_dir_q;
    y_dir_d  = y_dir_q;
    move     = 1'b0;
    bounce_x = 1'b0;
    bounce_y = 1'b0;
    x_ext    = {1'b0, box_x_q};
    y_ext    = {2'b00, box_y_q};

    // Tick only on entry into (0,0): a held (0,0) sees a zero registered
    // value after the first clk and stays quiet.
    frame_tick = (row_i == '0) && (column_i == '0) &&
                 ((row_q != '0) || (col_q != '0));

    if (frame_tick && !pause_i) begin
      if (cnt_q == DIV_LAST) begin
        cnt_d = '0;
        move  = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    if (move) begin
      case (x_dir_q)
        X_RIGHT: begin
          if (x_ext + STEP_W >= X_MAX) begin
            box_x_d  = X_MAX[9:0];
            x_dir_d  = X_LEFT;
            bounce_x = 1'b1;
          end else begin
            box_x_d = 10'(x_ext + STEP_W);
          end
        end
        default: begin
          if (x_ext <= STEP_W) begin
            box_x_d  = '0;
            x_dir_d  = X_RIGHT;
            bounce_x = 1'b1;
          end else begin
            box_x_d = 10'(x_ext - STEP_W);
          end
        end
      endcase

      case (y_dir_q)
        Y_DOWN: begin
          if (y_ext + STEP_W >= Y_MAX) begin
            box_y_d  = Y_MAX[8:0];
            y_dir_d  = Y_UP;
            bounce_y = 1'b1;
          end else begin
            box_y_d = 9'(y_ext + STEP_W);
          end
        end
        default: begin
          if (y_ext <= STEP_W) begin
            box_y_d  = '0;
            y_dir_d  = Y_DOWN;
            bounce_y = 1'b1;
          end else begin
            box_y_d = 9'(y_ext - STEP_W);
          end
        end
      endcase

      // A corner hit bounces both axes but advances the colour only once.
      if (bounce_x || bounce_y) colour_d = next_colour(colour_q);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      row_q    <= '0;
      col_q    <= '0;
      cnt_q    <= '0;
      box_x_q  <= '0;
      box_y_q  <= '0;
      colour_q <= 3'b100;
      x_dir_q  <= X_RIGHT;
      y_dir_q  <= Y_DOWN;
    end else begin
      row_q    <= row_d;
      col_q    <= col_d;
      cnt_q    <= cnt_d;
      box_x_q  <= box_x_d;
      box_y_q  <= box_y_d;
      colour_q <= colour_d;
      x_dir_q  <= x_dir_d;
      y_dir_q  <= y_dir_d;
    end
  end

  // Pixel colour: off-screen black, then box, then white border, else black.
  always_comb begin
    c_ext = {1'b0, column_i};
    r_ext = {2'b00, row_i};
    if (c_ext >= H_W || r_ext >= V_W) begin
      rgb_o = 3'b000;
    end else if (c_ext >= x_ext && c_ext < x_ext + BOX_W &&
                 r_ext >= y_ext && r_ext < y_ext + BOX_W) begin
      rgb_o = colour_q;
    end else if (row_i == '0 || r_ext == V_W - 11'd1 ||
                 column_i == '0 || c_ext == H_W - 11'd1) begin
      rgb_o = 3'b111;
    end else begin
      rgb_o = 3'b000;
    end
  end

  assign frame_tick_o = frame_tick;
  assign box_x_o      = box_x_q;
  assign box_y_o      = box_y_q;

endmodule

// File: tb/tb_bounce_box_gen.sv
// Directed bench for bounce_box_gen. Four instances share clock, reset and
// scan position: default geometry, a square screen (corner bounce), a
// narrow STEP=3 screen (left-edge bounce from x=1) and FRAME_DIV=3 (pause).
module tb_bounce_box_gen;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pause;
  logic       pause_div;
  logic [8:0] row;
  logic [9:0] col;

  logic [2:0] rgb_a, rgb_s, rgb_l, rgb_d;
  logic       tick_a, tick_s, tick_l, tick_d;
  logic [9:0] bx_a, bx_s, bx_l, bx_d;
  logic [8:0] by_a, by_s, by_l, by_d;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bounce_box_gen dut_a (
    .clk_i(clk), .reset_i(reset_n), .pause_i(pause), .row_i(row), .column_i(col),
    .rgb_o(rgb_a), .frame_tick_o(tick_a), .box_x_o(bx_a), .box_y_o(by_a));

  bounce_box_gen #(.H_ACTIVE(64), .V_ACTIVE(64), .BOX_SIZE(8), .STEP(2), .FRAME_DIV(1)) dut_s (
    .clk_i(clk), .reset_i(reset_n), .pause_i(pause), .row_i(row), .column_i(col),
    .rgb_o(rgb_s), .frame_tick_o(tick_s), .box_x_o(bx_s), .box_y_o(by_s));

  bounce_box_gen #(.H_ACTIVE(42), .V_ACTIVE(480), .BOX_SIZE(8), .STEP(3), .FRAME_DIV(1)) dut_l (
    .clk_i(clk), .reset_i(reset_n), .pause_i(pause), .row_i(row), .column_i(col),
    .rgb_o(rgb_l), .frame_tick_o(tick_l), .box_x_o(bx_l), .box_y_o(by_l));

  bounce_box_gen #(.FRAME_DIV(3)) dut_d (
    .clk_i(clk), .reset_i(reset_n), .pause_i(pause_div), .row_i(row), .column_i(col),
    .rgb_o(rgb_d), .frame_tick_o(tick_d), .box_x_o(bx_d), .box_y_o(by_d));

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0; pause = 1'b0; pause_div = 1'b0; row = '0; col = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // n frame starts: leave (0,0) for one clk, return for one clk.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); row = 9'd0; col = 10'd1;
      @(negedge clk); row = 9'd0; col = 10'd0;
    end
    @(negedge clk); row = 9'd1; col = 10'd1;
    #1;
  endtask

  task automatic probe(input logic [8:0] r, input logic [9:0] c);
    @(negedge clk); row = r; col = c;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0; pause = 1'b0; pause_div = 1'b0; row = 9'd5; col = 10'd5;
    #1;
    if (bx_a !== 10'd0) begin n_fail++; $display("FAIL reset_box_x: got %0d want 0", bx_a); end
    n_cmp++;
    if (by_a !== 9'd0) begin n_fail++; $display("FAIL reset_box_y: got %0d want 0", by_a); end
    n_cmp++;
    if (rgb_a !== 3'b100) begin n_fail++; $display("FAIL reset_colour: got %b want 100", rgb_a); end
    n_cmp++;
    row = '0; col = '0;
    #1;
    if (tick_a !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", tick_a); end
    n_cmp++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_first_frame();
    int pulses;
    apply_reset();
    pulses = 0;
    // Scan starts at (0,0) right after reset: must not tick.
    repeat (3) begin
      @(negedge clk); #1;
      if (tick_a === 1'b1) pulses++;
    end
    @(negedge clk); row = 9'd0;   col = 10'd1;   #1; if (tick_a === 1'b1) pulses++;
    @(negedge clk); row = 9'd200; col = 10'd300; #1; if (tick_a === 1'b1) pulses++;
    @(negedge clk); row = 9'd479; col = 10'd639; #1; if (tick_a === 1'b1) pulses++;
    @(negedge clk); row = 9'd0;   col = 10'd0;   #1; if (tick_a === 1'b1) pulses++;
    @(negedge clk); #1; if (tick_a === 1'b1) pulses++;
    if (pulses !== 1) begin n_fail++; $display("FAIL first_frame_pulses: got %0d want 1", pulses); end
    n_cmp++;
    if (bx_a !== 10'd2) begin n_fail++; $display("FAIL first_frame_box_x: got %0d want 2", bx_a); end
    n_cmp++;
    if (by_a !== 9'd2) begin n_fail++; $display("FAIL first_frame_box_y: got %0d want 2", by_a); end
    n_cmp++;
    probe(9'd5, 10'd5);
    if (rgb_a !== 3'b100) begin n_fail++; $display("FAIL rgb_box: got %b want 100", rgb_a); end
    n_cmp++;
    probe(9'd0, 10'd300);
    if (rgb_a !== 3'b111) begin n_fail++; $display("FAIL rgb_top_border: got %b want 111", rgb_a); end
    n_cmp++;
    probe(9'd200, 10'd300);
    if (rgb_a !== 3'b000) begin n_fail++; $display("FAIL rgb_background: got %b want 000", rgb_a); end
    n_cmp++;
    probe(9'd100, 10'd700);
    if (rgb_a !== 3'b000) begin n_fail++; $display("FAIL rgb_offscreen_col: got %b want 000", rgb_a); end
    n_cmp++;
    probe(9'd480, 10'd100);
    if (rgb_a !== 3'b000) begin n_fail++; $display("FAIL rgb_offscreen_row: got %b want 000", rgb_a); end
    n_cmp++;
    probe(9'd479, 10'd300);
    if (rgb_a !== 3'b111) begin n_fail++; $display("FAIL rgb_bottom_border: got %b want 111", rgb_a); end
    n_cmp++;
    probe(9'd100, 10'd639);
    if (rgb_a !== 3'b111) begin n_fail++; $display("FAIL rgb_right_border: got %b want 111", rgb_a); end
    n_cmp++;
    probe(9'd100, 10'd0);
    if (rgb_a !== 3'b111) begin n_fail++; $display("FAIL rgb_left_border: got %b want 111", rgb_a); end
    n_cmp++;
    probe(9'd33, 10'd33);
    if (rgb_a !== 3'b100) begin n_fail++; $display("FAIL rgb_box_last_px: got %b want 100", rgb_a); end
    n_cmp++;
    probe(9'd34, 10'd33);
    if (rgb_a !== 3'b000) begin n_fail++; $display("FAIL rgb_below_box: got %b want 000", rgb_a); end
    n_cmp++;
    probe(9'd1, 10'd1);
    if (rgb_a !== 3'b000) begin n_fail++; $display("FAIL rgb_left_of_box: got %b want 000", rgb_a); end
    n_cmp++;
  endtask

  task automatic test_x_bounce();
    apply_reset();
    // Y bounces at tick 224 (448), then falls 2 per tick: 290 at tick 303.
    ticks(303);
    if (bx_a !== 10'd606 || by_a !== 9'd290) begin
      n_fail++; $display("FAIL pre_x_bounce_pos: got %0d,%0d want 606,290", bx_a, by_a);
    end
    n_cmp++;
    probe(9'd295, 10'd611);
    if (rgb_a !== 3'b010) begin n_fail++; $display("FAIL pre_x_bounce_colour: got %b want 010", rgb_a); end
    n_cmp++;
    ticks(1);
    if (bx_a !== 10'd608 || by_a !== 9'd288) begin
      n_fail++; $display("FAIL x_bounce_pos: got %0d,%0d want 608,288", bx_a, by_a);
    end
    n_cmp++;
    probe(9'd293, 10'd613);
    if (rgb_a !== 3'b001) begin n_fail++; $display("FAIL x_bounce_colour: got %b want 001", rgb_a); end
    n_cmp++;
    ticks(1);
    if (bx_a !== 10'd606 || by_a !== 9'd286) begin
      n_fail++; $display("FAIL after_x_bounce_pos: got %0d,%0d want 606,286", bx_a, by_a);
    end
    n_cmp++;
  endtask

  task automatic test_corner();
    apply_reset();
    ticks(27);
    if (bx_s !== 10'd54 || by_s !== 9'd54) begin
      n_fail++; $display("FAIL pre_corner_pos: got %0d,%0d want 54,54", bx_s, by_s);
    end
    n_cmp++;
    ticks(1);
    if (bx_s !== 10'd56 || by_s !== 9'd56) begin
      n_fail++; $display("FAIL corner_pos: got %0d,%0d want 56,56", bx_s, by_s);
    end
    n_cmp++;
    probe(9'd58, 10'd58);
    if (rgb_s !== 3'b010) begin n_fail++; $display("FAIL corner_colour_once: got %b want 010", rgb_s); end
    n_cmp++;
    ticks(1);
    if (bx_s !== 10'd54 || by_s !== 9'd54) begin
      n_fail++; $display("FAIL after_corner_pos: got %0d,%0d want 54,54", bx_s, by_s);
    end
    n_cmp++;
  endtask

  task automatic test_left_bounce();
    apply_reset();
    // Right edge at 34 (tick 12), then 34-3k reaches 1 at tick 23.
    ticks(23);
    if (bx_l !== 10'd1 || by_l !== 9'd69) begin
      n_fail++; $display("FAIL pre_left_pos: got %0d,%0d want 1,69", bx_l, by_l);
    end
    n_cmp++;
    ticks(1);
    if (bx_l !== 10'd0 || by_l !== 9'd72) begin
      n_fail++; $display("FAIL left_bounce_pos: got %0d,%0d want 0,72", bx_l, by_l);
    end
    n_cmp++;
    // Column 0 is border, but the box overlaps it and wins.
    probe(9'd72, 10'd0);
    if (rgb_l !== 3'b001) begin n_fail++; $display("FAIL left_bounce_colour: got %b want 001", rgb_l); end
    n_cmp++;
    ticks(1);
    if (bx_l !== 10'd3) begin n_fail++; $display("FAIL after_left_x: got %0d want 3", bx_l); end
    n_cmp++;
  endtask

  task automatic test_pause_div();
    apply_reset();
    ticks(2);
    if (bx_d !== 10'd0) begin n_fail++; $display("FAIL div_two_ticks: got %0d want 0", bx_d); end
    n_cmp++;
    ticks(1);
    if (bx_d !== 10'd2 || by_d !== 9'd2) begin
      n_fail++; $display("FAIL div_third_tick: got %0d,%0d want 2,2", bx_d, by_d);
    end
    n_cmp++;
    pause_div = 1'b1;
    ticks(2);
    if (bx_d !== 10'd2 || by_d !== 9'd2) begin
      n_fail++; $display("FAIL div_paused: got %0d,%0d want 2,2", bx_d, by_d);
    end
    n_cmp++;
    probe(9'd5, 10'd5);
    if (rgb_d !== 3'b100) begin n_fail++; $display("FAIL div_paused_colour: got %b want 100", rgb_d); end
    n_cmp++;
    pause_div = 1'b0;
    ticks(2);
    if (bx_d !== 10'd2) begin n_fail++; $display("FAIL div_paused_ticks_ignored: got %0d want 2", bx_d); end
    n_cmp++;
    ticks(1);
    if (bx_d !== 10'd4 || by_d !== 9'd4) begin
      n_fail++; $display("FAIL div_sixth_tick: got %0d,%0d want 4,4", bx_d, by_d);
    end
    n_cmp++;
  endtask

  task automatic test_hold_and_reset();
    int pulses;
    apply_reset();
    @(negedge clk); row = 9'd0; col = 10'd5;
    pulses = 0;
    repeat (4) begin
      @(negedge clk); row = 9'd0; col = 10'd0;
      #1;
      if (tick_a === 1'b1) pulses++;
    end
    if (pulses !== 1) begin n_fail++; $display("FAIL hold_pulses: got %0d want 1", pulses); end
    n_cmp++;
    @(negedge clk); row = 9'd100; col = 10'd100;
    #1;
    if (bx_a !== 10'd2) begin n_fail++; $display("FAIL hold_moved_once: got %0d want 2", bx_a); end
    n_cmp++;
    // Mid-cycle reset with the scan jumping to (0,0): would tick without reset.
    @(posedge clk); #2;
    row = '0; col = '0; reset_n = 1'b0;
    #1;
    if (bx_a !== 10'd0 || by_a !== 9'd0) begin
      n_fail++; $display("FAIL async_reset_pos: got %0d,%0d want 0,0", bx_a, by_a);
    end
    n_cmp++;
    if (tick_a !== 1'b0) begin n_fail++; $display("FAIL async_reset_tick: got %b want 0", tick_a); end
    n_cmp++;
    @(negedge clk); reset_n = 1'b1;
    pulses = 0;
    repeat (2) begin
      @(negedge clk); #1;
      if (tick_a === 1'b1) pulses++;
    end
    if (pulses !== 0) begin n_fail++; $display("FAIL post_reset_no_tick: got %0d want 0", pulses); end
    n_cmp++;
  endtask

  initial begin
    reset_n = 1'b0; pause = 1'b0; pause_div = 1'b0; row = '0; col = '0;
    test_reset();
    test_first_frame();
    test_x_bounce();
    test_corner();
    test_left_bounce();
    test_pause_div();
    test_hold_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
